jump_ctl: RTL and testbench
===========================

# jump_ctl

Frame-paced jump/walk sequencer for the player sprite: turns keyboard levels into Jump King-style charge-and-release jumps and ground walking. Issues one launch command per jump to the physics/position datapath over a valid/ready handshake, plus per-frame walk steps. Sits between the keyboard decoder and the rectangle position controller; all decisions are taken on the per-frame tick.

## Interface
- MAX_CHARGE, 35: charge saturation value, in frames.
- V_MIN, 4: launch speed at charge 0, in px/frame.
- V_STEP, 1: speed added per charge unit.
- VX_JUMP, 6: horizontal launch speed magnitude.
- WALK_STEP, 2: ground walk step, px/frame.
- LAND_FRAMES, 4: landing recovery frames.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- key_space, key_left, key_right  in  1 each  key levels, already in clk domain.
- on_ground  in  1  datapath flag: sprite resting on floor/platform.
- cmd_ready  in  1  datapath accepts launch command.
- cmd_valid  out  1  launch command pending.
- cmd_vx, cmd_vy  out  12 signed each  launch velocity; negative vy = upward.
- walk_valid  out  1  one-cycle walk-step strobe.
- walk_dx  out  12 signed  walk displacement.
- charge  out  6  current charge level (HUD).
- state_o  out  3  current state encoding.

## Operation
- States: GROUND, CHARGE, LAUNCH, AIRBORNE, LAND. Reset -> GROUND; every output 0.
- Decisions are taken only on cycles with frame_tick=1, except the LAUNCH handshake, which is evaluated every clock.
- GROUND, on tick: on_ground=0 -> AIRBORNE (walked off a ledge). Else space=1 -> CHARGE with charge=0. Else walk.
- Walk: exactly one of left/right held -> walk_valid pulse, walk_dx = -WALK_STEP (left) or +WALK_STEP (right). Both or neither held -> no pulse.
- CHARGE, on tick with space=1: charge = min(charge+1, MAX_CHARGE). No walking.
- CHARGE, on tick with space=0: latch direction (left-only -1, right-only +1, else 0), then -> LAUNCH.
- Launch velocities: cmd_vy = -(V_MIN + charge*V_STEP); cmd_vx = dir*VX_JUMP. Product computed at 12 bits signed; parameters are legal only if V_MIN + MAX_CHARGE*V_STEP ≤ 2047.
- LAUNCH: cmd_valid=1, with cmd_vx/cmd_vy held stable until the transfer cycle (cmd_valid & cmd_ready). On transfer -> AIRBORNE and charge cleared to 0. frame_tick and keys are ignored in this state.
- AIRBORNE: an internal armed flag is cleared on entry and set at the first tick with on_ground=0. A tick with on_ground=1 and armed=1 -> LAND, with the land counter loaded to LAND_FRAMES.
- LAND: each tick decrements the land counter; a tick with counter=1 -> GROUND. Keys are ignored. LAND_FRAMES=0 means LAND is skipped (AIRBORNE -> GROUND directly).

## Timing
- All outputs are registered. A decision on tick cycle T is visible at cycle T+1.
- walk_valid is high for exactly cycle T+1.
- cmd_valid rises at T+1 after the release tick. cmd_valid=1 with cmd_ready=1 in the same cycle is a transfer, and cmd_valid is 0 the next cycle. cmd_ready while cmd_valid=0 is ignored.
- rst mid-LAUNCH: cmd_valid=0 on the next cycle and no transfer is counted.
- frame_tick coinciding with the transfer cycle has no further effect.

## Configuration
- JUMP_CTL_AUTO_RELEASE_EN defined: in CHARGE, a tick that brings charge to MAX_CHARGE goes directly to LAUNCH, sampling direction on that same tick, even if space is still held. After landing, space must be seen low on at least one tick before a new CHARGE can start.
- Undefined: charge saturates and holds at MAX_CHARGE until space is released.

## Structure
- Shared package jk_pkg: state enum jump_state_t, screen constants, and default physics constants (V_MIN, V_STEP, VX_JUMP, WALK_STEP).
- One sub-module, jump_vel_calc: combinational charge + direction -> cmd_vx/cmd_vy. It is registered by jump_ctl at LAUNCH entry.

## Test plan
- Reset, then 3 ticks with no keys -> state GROUND, no walk_valid, all outputs 0.
- GROUND, right held for 3 ticks -> 3 walk_valid pulses with walk_dx=+2; left+right held -> no pulses.
- Space held for 10 ticks, then released with right held; cmd_ready held low for 5 cycles -> cmd_vy=-14, cmd_vx=+6, both stable while cmd_valid=1; transfer on the cycle cmd_ready=1; then AIRBORNE and charge=0.
- Space held for 50 ticks -> charge=35. Release -> cmd_vy=-39, and with JUMP_CTL_AUTO_RELEASE_EN defined, cmd_valid rises after the 35th tick instead.
- AIRBORNE: on_ground held 1 for 2 ticks -> stays AIRBORNE. Then 0 for 1 tick, then 1 -> LAND; GROUND follows after 4 more ticks.
- rst asserted while cmd_valid=1 -> cmd_valid=0 and state GROUND on the next cycle.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and constants for the player jump/walk sequencer.
package jk_pkg;

  typedef enum logic [2:0] {
    ST_GROUND   = 3'd0,
    ST_CHARGE   = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_AIRBORNE = 3'd3,
    ST_LAND     = 3'd4
  } jump_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned CMD_W    = 12;
  localparam int unsigned CHARGE_W = 6;
  localparam int unsigned STATE_W  = 3;

  localparam int unsigned MAX_CHARGE_DEF  = 35;
  localparam int unsigned V_MIN_DEF       = 4;
  localparam int unsigned V_STEP_DEF      = 1;
  localparam int unsigned VX_JUMP_DEF     = 6;
  localparam int unsigned WALK_STEP_DEF   = 2;
  localparam int unsigned LAND_FRAMES_DEF = 4;

  // Horizontal intent from key levels: -1 left only, +1 right only, else 0.
  function automatic logic signed [1:0] key_dir(input logic left, input logic right);
    if (left && !right)      return -2'sd1;
    else if (right && !left) return 2'sd1;
    else                     return 2'sd0;
  endfunction

endpackage

// File: rtl/jump_vel_calc.sv
// Combinational launch velocity from charge level and horizontal direction.
module jump_vel_calc
  import jk_pkg::*;
#(
  parameter int unsigned V_MIN   = V_MIN_DEF,
  parameter int unsigned V_STEP  = V_STEP_DEF,
  parameter int unsigned VX_JUMP = VX_JUMP_DEF
) (
  input  logic [CHARGE_W-1:0]     charge_i,
  input  logic signed [1:0]       dir_i,
  output logic signed [CMD_W-1:0] vx_o,
  output logic signed [CMD_W-1:0] vy_o
);

  logic [CMD_W-1:0] mag_c;

  always_comb begin
    mag_c = CMD_W'(V_MIN) + CMD_W'(charge_i) * CMD_W'(V_STEP);
    // Upward launch is negative vy.
    vy_o  = -$signed(mag_c);
    case (dir_i)
      2'b01:   vx_o = $signed(CMD_W'(VX_JUMP));
      2'b11:   vx_o = -$signed(CMD_W'(VX_JUMP));
      default: vx_o = '0;
    endcase
  end

endmodule

// File: rtl/jump_ctl.sv
// Frame-paced charge-and-release jump / ground walk sequencer for the player sprite.
// Optional feature macro: JUMP_CTL_AUTO_RELEASE_EN (launch automatically at full charge).
module jump_ctl
  import jk_pkg::*;
#(
  parameter int unsigned MAX_CHARGE  = MAX_CHARGE_DEF,
  parameter int unsigned V_MIN       = V_MIN_DEF,
  parameter int unsigned V_STEP      = V_STEP_DEF,
  parameter int unsigned VX_JUMP     = VX_JUMP_DEF,
  parameter int unsigned WALK_STEP   = WALK_STEP_DEF,
  parameter int unsigned LAND_FRAMES = LAND_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    key_space,
  input  logic                    key_left,
  input  logic                    key_right,
  input  logic                    on_ground,
  input  logic                    cmd_ready,
  output logic                    cmd_valid,
  output logic signed [CMD_W-1:0] cmd_vx,
  output logic signed [CMD_W-1:0] cmd_vy,
  output logic                    walk_valid,
  output logic signed [CMD_W-1:0] walk_dx,
  output logic [CHARGE_W-1:0]     charge,
  output logic [STATE_W-1:0]      state_o
);

  localparam int unsigned LCW = (LAND_FRAMES < 2) ? 1 : $clog2(LAND_FRAMES + 1);
  localparam logic signed [CMD_W-1:0] WALK_POS = CMD_W'(WALK_STEP);
  localparam logic signed [CMD_W-1:0] WALK_NEG = -WALK_POS;

  jump_state_t             state_q, state_d;
  logic [CHARGE_W-1:0]     charge_q, charge_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic signed [CMD_W-1:0] cmd_vx_q, cmd_vx_d;
  logic signed [CMD_W-1:0] cmd_vy_q, cmd_vy_d;
  logic                    walk_valid_q, walk_valid_d;
  logic signed [CMD_W-1:0] walk_dx_q, walk_dx_d;
  logic                    armed_q, armed_d;
  logic [LCW-1:0]          land_cnt_q, land_cnt_d;

  logic signed [1:0]       dir_c;
  logic [CHARGE_W-1:0]     charge_inc_c;
  logic [CHARGE_W-1:0]     vel_charge_c;
  logic signed [CMD_W-1:0] vel_vx_c, vel_vy_c;
  logic                    start_ok_c;

  assign dir_c        = key_dir(key_left, key_right);
  assign charge_inc_c = (charge_q < CHARGE_W'(MAX_CHARGE)) ? charge_q + CHARGE_W'(1) : charge_q;

`ifdef JUMP_CTL_AUTO_RELEASE_EN
  // Set by an automatic launch; a tick with space low must be seen before recharging.
  logic need_rel_q, need_rel_d;

  assign vel_charge_c = key_space ? charge_inc_c : charge_q;
  assign start_ok_c   = !need_rel_q;
`else
  assign vel_charge_c = charge_q;
  assign start_ok_c   = 1'b1;
`endif

  jump_vel_calc #(
    .V_MIN   (V_MIN),
    .V_STEP  (V_STEP),
    .VX_JUMP (VX_JUMP)
  ) u_vel (
    .charge_i (vel_charge_c),
    .dir_i    (dir_c),
    .vx_o     (vel_vx_c),
    .vy_o     (vel_vy_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GROUND;
      charge_q     <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_vx_q     <= '0;
      cmd_vy_q     <= '0;
      walk_valid_q <= 1'b0;
      walk_dx_q    <= '0;
      armed_q      <= 1'b0;
      land_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      charge_q     <= charge_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_vx_q     <= cmd_vx_d;
      cmd_vy_q     <= cmd_vy_d;
      walk_valid_q <= walk_valid_d;
      walk_dx_q    <= walk_dx_d;
      armed_q      <= armed_d;
      land_cnt_q   <= land_cnt_d;
    end
  end

`ifdef JUMP_CTL_AUTO_RELEASE_EN
  always_ff @(posedge clk) begin
    if (rst) need_rel_q <= 1'b0;
    else     need_rel_q <= need_rel_d;
  end
`endif

  // Next-state and output decisions; only LAUNCH reacts between frame ticks.
  always_comb begin
    state_d      = state_q;
    charge_d     = charge_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_vx_d     = cmd_vx_q;
    cmd_vy_d     = cmd_vy_q;
    walk_valid_d = 1'b0;
    walk_dx_d    = '0;
    armed_d      = armed_q;
    land_cnt_d   = land_cnt_q;
`ifdef JUMP_CTL_AUTO_RELEASE_EN
    need_rel_d   = need_rel_q;
    if (frame_tick && !key_space && state_q != ST_LAUNCH) need_rel_d = 1'b0;
`endif

    case (state_q)
      ST_GROUND: begin
        if (frame_tick) begin
          if (!on_ground) begin
            state_d = ST_AIRBORNE;
            armed_d = 1'b0;
          end else if (key_space && start_ok_c) begin
            state_d  = ST_CHARGE;
            charge_d = '0;
          end else if (key_left ^ key_right) begin
            walk_valid_d = 1'b1;
            walk_dx_d    = key_left ? WALK_NEG : WALK_POS;
          end
        end
      end

      ST_CHARGE: begin
        if (frame_tick) begin
          if (key_space) begin
            charge_d = charge_inc_c;
`ifdef JUMP_CTL_AUTO_RELEASE_EN
            if (charge_inc_c == CHARGE_W'(MAX_CHARGE)) begin
              state_d     = ST_LAUNCH;
              cmd_valid_d = 1'b1;
              cmd_vx_d    = vel_vx_c;
              cmd_vy_d    = vel_vy_c;
              need_rel_d  = 1'b1;
            end
`endif
          end else begin
            state_d     = ST_LAUNCH;
            cmd_valid_d = 1'b1;
            cmd_vx_d    = vel_vx_c;
            cmd_vy_d    = vel_vy_c;
          end
        end
      end

      ST_LAUNCH: begin
        if (cmd_ready) begin
          state_d     = ST_AIRBORNE;
          cmd_valid_d = 1'b0;
          charge_d    = '0;
          armed_d     = 1'b0;
        end
      end

      ST_AIRBORNE: begin
        if (frame_tick) begin
          if (!on_ground) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            if (LAND_FRAMES == 0) begin
              state_d = ST_GROUND;
            end else begin
              state_d    = ST_LAND;
              land_cnt_d = LCW'(LAND_FRAMES);
            end
          end
        end
      end

      ST_LAND: begin
        if (frame_tick) begin
          if (land_cnt_q <= LCW'(1)) begin
            state_d    = ST_GROUND;
            land_cnt_d = '0;
          end else begin
            land_cnt_d = land_cnt_q - LCW'(1);
          end
        end
      end

      default: state_d = ST_GROUND;
    endcase
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_vx     = cmd_vx_q;
  assign cmd_vy     = cmd_vy_q;
  assign walk_valid = walk_valid_q;
  assign walk_dx    = walk_dx_q;
  assign charge     = charge_q;
  assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_jump_ctl.sv
// Self-checking bench for jump_ctl: per-cycle reference model plus literal pins.
`timescale 1ns/1ps
module tb_jump_ctl;

  localparam int MAXC  = 35;
  localparam int VMIN  = 4;
  localparam int VSTEP = 1;
  localparam int VXJ   = 6;
  localparam int WSTEP = 2;
  localparam int LANDF = 4;

  localparam int S_GROUND = 0;
  localparam int S_CHARGE = 1;
  localparam int S_LAUNCH = 2;
  localparam int S_AIR    = 3;
  localparam int S_LAND   = 4;

  logic clk = 1'b0;
  logic rst, frame_tick, key_space, key_left, key_right, on_ground, cmd_ready;
  logic cmd_valid, walk_valid;
  logic signed [11:0] cmd_vx, cmd_vy, walk_dx;
  logic [5:0] charge;
  logic [2:0] state_o;

  jump_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .key_space  (key_space),
    .key_left   (key_left),
    .key_right  (key_right),
    .on_ground  (on_ground),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_vx     (cmd_vx),
    .cmd_vy     (cmd_vy),
    .walk_valid (walk_valid),
    .walk_dx    (walk_dx),
    .charge     (charge),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int walk_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: mode, charge, launch command and walk strobe derived from the rules.
  int m_state, m_charge, m_armed, m_land, m_needrel;
  int m_valid, m_vx, m_vy, m_walk, m_dx;
  int cur, d;

  task automatic do_launch(input int c, input int dir);
    m_state = S_LAUNCH;
    m_valid = 1;
    m_vx    = dir * VXJ;
    m_vy    = -(VMIN + c * VSTEP);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_state = S_GROUND; m_charge = 0; m_armed = 0; m_land = 0; m_needrel = 0;
      m_valid = 0; m_vx = 0; m_vy = 0; m_walk = 0; m_dx = 0;
    end else begin
      cur    = m_state;
      m_walk = 0;
      m_dx   = 0;
      d = (key_left && !key_right) ? -1 : ((key_right && !key_left) ? 1 : 0);
      if (cur == S_LAUNCH) begin
        if (cmd_ready) begin
          m_valid = 0; m_state = S_AIR; m_charge = 0; m_armed = 0;
        end
      end else if (frame_tick) begin
        if (cur == S_GROUND) begin
          if (!on_ground) begin
            m_state = S_AIR; m_armed = 0;
          end else if (key_space && m_needrel == 0) begin
            m_state = S_CHARGE; m_charge = 0;
          end else if (d != 0) begin
            m_walk = 1; m_dx = d * WSTEP;
          end
        end else if (cur == S_CHARGE) begin
          if (key_space) begin
            m_charge = (m_charge < MAXC) ? m_charge + 1 : MAXC;
`ifdef JUMP_CTL_AUTO_RELEASE_EN
            if (m_charge == MAXC) begin
              do_launch(m_charge, d);
              m_needrel = 1;
            end
`endif
          end else begin
            do_launch(m_charge, d);
          end
        end else if (cur == S_AIR) begin
          if (!on_ground) m_armed = 1;
          else if (m_armed == 1) begin
            m_state = S_LAND; m_land = LANDF;
          end
        end else if (cur == S_LAND) begin
          m_land = m_land - 1;
          if (m_land == 0) m_state = S_GROUND;
        end
`ifdef JUMP_CTL_AUTO_RELEASE_EN
        if (!key_space) m_needrel = 0;
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (walk_valid) walk_cnt++;
    if (chk_en) begin
      chk("state", int'(state_o), m_state);
      chk("charge", int'(charge), m_charge);
      chk("cmd_valid", int'(cmd_valid), m_valid);
      chk("walk_valid", int'(walk_valid), m_walk);
      if (m_walk != 0) chk("walk_dx", int'(walk_dx), m_dx);
      if (m_valid != 0) begin
        chk("cmd_vx", int'(cmd_vx), m_vx);
        chk("cmd_vy", int'(cmd_vy), m_vy);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; key_space = 1'b0; key_left = 1'b0;
    key_right = 1'b0; on_ground = 1'b1; cmd_ready = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_cmd_vy", int'(cmd_vy), 0);
    chk("rst_charge", int'(charge), 0);
    rst = 1'b0;

    // Idle ticks
    tick_n(3);
    chk("idle_state", int'(state_o), S_GROUND);
    chk("idle_walks", walk_cnt, 0);

    // Walking
    key_right = 1'b1;
    tick_n(3);
    chk("right_walks", walk_cnt, 3);
    key_left = 1'b1;
    tick_n(2);
    chk("both_walks", walk_cnt, 3);
    key_right = 1'b0;
    tick_n(1);
    chk("left_walks", walk_cnt, 4);
    key_left = 1'b0;

    // Charge 10, release right, stalled handshake
    key_space = 1'b1;
    tick_n(1);
    chk("charge_entry", int'(state_o), S_CHARGE);
    tick_n(10);
    chk("charge10", int'(charge), 10);
    key_space = 1'b0; key_right = 1'b1;
    tick_n(1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", int'(cmd_valid), 1);
      chk("hold_vy", int'(cmd_vy), -14);
      chk("hold_vx", int'(cmd_vx), 6);
      cyc(1);
    end
    key_right = 1'b0;
    cmd_ready = 1'b1;
    cyc(1);
    cmd_ready = 1'b0;
    chk("xfer_valid", int'(cmd_valid), 0);
    chk("xfer_state", int'(state_o), S_AIR);
    chk("xfer_charge", int'(charge), 0);

    // Airborne arming and landing
    tick_n(2);
    chk("unarmed_air", int'(state_o), S_AIR);
    on_ground = 1'b0;
    tick_n(1);
    on_ground = 1'b1;
    tick_n(1);
    chk("land_entry", int'(state_o), S_LAND);
    tick_n(3);
    chk("land_hold", int'(state_o), S_LAND);
    tick_n(1);
    chk("land_done", int'(state_o), S_GROUND);

    // Saturating charge
    key_space = 1'b1;
    tick_n(1);
    tick_n(50);
    chk("charge_sat", int'(charge), 35);
`ifdef JUMP_CTL_AUTO_RELEASE_EN
    chk("auto_valid", int'(cmd_valid), 1);
    key_space = 1'b0;
`else
    chk("sat_no_launch", int'(cmd_valid), 0);
    key_space = 1'b0;
    tick_n(1);
`endif
    chk("sat_valid", int'(cmd_valid), 1);
    chk("sat_vy", int'(cmd_vy), -39);
    chk("sat_vx", int'(cmd_vx), 0);
    cmd_ready = 1'b1; frame_tick = 1'b1;
    cyc(1);
    cmd_ready = 1'b0; frame_tick = 1'b0;
    chk("tick_xfer_state", int'(state_o), S_AIR);
    chk("tick_xfer_valid", int'(cmd_valid), 0);
    on_ground = 1'b0;
    tick_n(1);
    on_ground = 1'b1;
    tick_n(5);
    chk("sat_land_done", int'(state_o), S_GROUND);

    // Walking off a ledge
    on_ground = 1'b0;
    tick_n(1);
    chk("ledge_air", int'(state_o), S_AIR);
    tick_n(1);
    on_ground = 1'b1;
    tick_n(5);
    chk("ledge_ground", int'(state_o), S_GROUND);

    // Reset during a pending launch
    key_space = 1'b1;
    tick_n(4);
    key_space = 1'b0; key_left = 1'b1;
    tick_n(1);
    chk("pre_rst_valid", int'(cmd_valid), 1);
    chk("pre_rst_vx", int'(cmd_vx), -6);
    chk("pre_rst_vy", int'(cmd_vy), -7);
    rst = 1'b1; cmd_ready = 1'b1;
    cyc(1);
    chk("rst_launch_valid", int'(cmd_valid), 0);
    chk("rst_launch_state", int'(state_o), S_GROUND);
    chk("rst_launch_charge", int'(charge), 0);
    rst = 1'b0; cmd_ready = 1'b0; key_left = 1'b0;
    tick_n(2);
    chk("post_rst_state", int'(state_o), S_GROUND);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
